gate_pattern_sequencer: RTL and testbench

Self-checking stimulus controller for 3-input combinational gate blocks (OR/AND/XOR/NOR families). It steps a 3-bit input pattern exhaustively from 000 to 111 into a gate under test, waits a programmable settle time, samples the gate output and compares it to the expected function. It accumulates an error count, records the first failing pattern, and reports pass/fail. It is a synthesizable on-board replacement for free-running toggle stimulus.

---
 rtl/gate_pattern_sequencer.sv | 122 ++++++++++++
 tb/tb_gate_pattern_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_pattern_sequencer.sv
// Exhaustive 3-input stimulus sequencer for gate blocks: steps patterns 000..111,
// settles, samples the gate output against the selected function and tallies errors.
module gate_pattern_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_gate_sel,
    input  logic       i_dut_out,
    output logic       o_pat_a,
    output logic       o_pat_b,
    output logic       o_pat_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_count,
    output logic [2:0] o_first_err_pat,
    output logic       o_first_err_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [2:0]       r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_gsel;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_err;
    logic [2:0]       r_fep;
    logic             r_fev;

    logic             w_expect;
    logic             w_mismatch;
    logic [3:0]       w_err_next;

    always_comb begin
        case (r_gsel)
            2'b00:   w_expect = |r_pat;
            2'b01:   w_expect = &r_pat;
            2'b10:   w_expect = ^r_pat;
            default: w_expect = ~|r_pat;
        endcase
    end

    assign w_mismatch = (i_dut_out != w_expect);
    // Final pass verdict must include a mismatch found in the last SAMPLE cycle.
    assign w_err_next = r_err + {3'b000, w_mismatch};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pat   <= 3'b000;
            r_cnt   <= '0;
            r_gsel  <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
            r_fep   <= 3'b000;
            r_fev   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_gsel  <= i_gate_sel;
                        r_err   <= 4'd0;
                        r_fep   <= 3'b000;
                        r_fev   <= 1'b0;
                        r_pat   <= 3'b000;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LP_CNT_LAST)
                        r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fev) begin
                        r_fep <= r_pat;
                        r_fev <= 1'b1;
                    end
                    if (r_pat == 3'b111) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                        r_state <= DONE;
                    end else begin
                        r_pat   <= r_pat + 3'd1;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_pat_a           = r_pat[2];
    assign o_pat_b           = r_pat[1];
    assign o_pat_c           = r_pat[0];
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_err_count       = r_err;
    assign o_first_err_pat   = r_fep;
    assign o_first_err_valid = r_fev;

endmodule

// File: tb/tb_gate_pattern_sequencer.sv
// Bench for gate_pattern_sequencer: two instances (settle 2 and settle 1) driven
// together, checked every cycle against a timeline model plus end-of-run table values.
module tb_gate_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] gsel;
    logic [1:0] dout;
    logic [1:0] pat_a, pat_b, pat_c, busy, done, pass, fev;
    logic [3:0] err [2];
    logic [2:0] fep [2];

    always #5 clk = ~clk;

    gate_pattern_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_gate_sel(gsel), .i_dut_out(dout[0]),
        .o_pat_a(pat_a[0]), .o_pat_b(pat_b[0]), .o_pat_c(pat_c[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_pass(pass[0]), .o_err_count(err[0]),
        .o_first_err_pat(fep[0]), .o_first_err_valid(fev[0]));

    gate_pattern_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_gate_sel(gsel), .i_dut_out(dout[1]),
        .o_pat_a(pat_a[1]), .o_pat_b(pat_b[1]), .o_pat_c(pat_c[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_pass(pass[1]), .o_err_count(err[1]),
        .o_first_err_pat(fep[1]), .o_first_err_valid(fev[1]));

    // Gates under test: 0 OR, 1 stuck-at-0, 2 random, 3 OR + 1 reg, 4 OR + 2 regs
    int         mode [2];
    logic [1:0] d1, d2, rnd;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            d1[i] <= pat_a[i] | pat_b[i] | pat_c[i];
            d2[i] <= d1[i];
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < 2; i++) begin
            case (mode[i])
                0:       dout[i] = pat_a[i] | pat_b[i] | pat_c[i];
                1:       dout[i] = 1'b0;
                2:       dout[i] = rnd[i];
                3:       dout[i] = d1[i];
                default: dout[i] = d2[i];
            endcase
        end
    end

    // Reference model: run timeline relative to the accepted start cycle
    int SS [2] = '{2, 1};
    int m_act [2], m_t0 [2], m_err [2], m_fep [2], m_fev [2], m_pass [2], m_last [2], m_g [2];
    int cyc = 0;
    int ntests = 0;
    int nfail = 0;

    function automatic int gexp(int g, int p);
        int n;
        n = (p & 1) + ((p >> 1) & 1) + ((p >> 2) & 1);
        case (g)
            0:       return (n > 0) ? 1 : 0;
            1:       return (n == 3) ? 1 : 0;
            2:       return n % 2;
            default: return (n == 0) ? 1 : 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t0[i] = 0; m_err[i] = 0; m_fep[i] = 0;
            m_fev[i] = 0; m_pass[i] = 0; m_last[i] = 0; m_g[i] = 0;
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            int p, b, d, rel, per;
            logic [13:0] e, a;
            per = SS[i] + 1;
            rel = cyc - m_t0[i];
            if (m_act[i] != 0 && rel <= 8 * per) begin
                p = (rel - 1) / per; b = 1; d = 0;
            end else if (m_act[i] != 0) begin
                p = 7; b = 0; d = 1;
            end else begin
                p = m_last[i]; b = 0; d = 0;
            end
            e = {3'(p), 1'(b), 1'(d), 1'(m_pass[i]), 4'(m_err[i]), 3'(m_fep[i]), 1'(m_fev[i])};
            a = {pat_a[i], pat_b[i], pat_c[i], busy[i], done[i], pass[i], err[i], fep[i], fev[i]};
            ntests++;
            if (a !== e) begin
                nfail++;
                $display("FAIL cycle%0d dut%0d {pat,busy,done,pass,err,fep,fev} got %b want %b",
                         cyc, i, a, e);
            end
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int rel, per, k;
            per = SS[i] + 1;
            rel = cyc - m_t0[i];
            if (rst) begin
                m_act[i] = 0; m_err[i] = 0; m_fep[i] = 0; m_fev[i] = 0;
                m_pass[i] = 0; m_last[i] = 0;
            end else if (m_act[i] != 0) begin
                if (rel >= 1 && rel <= 8 * per && rel % per == 0) begin
                    k = rel / per - 1;
                    if (int'(dout[i]) != gexp(m_g[i], k)) begin
                        m_err[i]++;
                        if (m_fev[i] == 0) begin
                            m_fep[i] = k; m_fev[i] = 1;
                        end
                    end
                    if (rel == 8 * per) m_pass[i] = (m_err[i] == 0) ? 1 : 0;
                end
                if (rel == 8 * per + 1) begin
                    m_act[i] = 0; m_last[i] = 7;
                end
            end else if (start) begin
                m_act[i] = 1; m_t0[i] = cyc; m_g[i] = int'(gsel);
                m_err[i] = 0; m_fep[i] = 0; m_fev[i] = 0;
            end
        end
    endtask

    typedef struct {
        int gsel, m0, m1, restart_at, rst_at, toggle, e_err0, e_fep0, e_pass0, e_err1;
    } vec_t;

    task automatic run(input vec_t v);
        mode[0] = v.m0;
        mode[1] = v.m1;
        for (int t = 0; t < 28; t++) begin
            @(negedge clk);
            check_cycle();
            rst   = (v.rst_at >= 0 && (t == v.rst_at || t == v.rst_at + 1));
            start = (t == 0) || (t == v.restart_at) || rst;
            gsel  = (t == 0 || v.toggle == 0) ? 2'(v.gsel) : 2'($urandom_range(0, 3));
            rnd   = 2'($urandom);
            #1;
            model_update();
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        start = 1'b0;
        if (v.e_err0 >= 0) begin
            logic [8:0] a0, e0;
            a0 = {err[0], fep[0], fev[0], pass[0]};
            e0 = {4'(v.e_err0), 3'(v.e_fep0), (v.e_err0 != 0), 1'(v.e_pass0)};
            ntests++;
            if (a0 !== e0) begin
                nfail++;
                $display("FAIL end-of-run dut0 {err,fep,fev,pass} got %b want %b", a0, e0);
            end
            if (v.e_err1 >= 0) begin
                ntests++;
                if (err[1] !== 4'(v.e_err1)) begin
                    nfail++;
                    $display("FAIL end-of-run dut1 err_count got %0d want %0d", err[1], v.e_err1);
                end
            end
        end
    endtask

    vec_t tbl [12];

    initial begin
        //            gsel m0 m1 rs  rst tg err0 fep0 pass0 err1
        tbl[0]  = '{0, 0, 0, -1, -1, 0, 0, 0, 1, 0};   // correct OR
        tbl[1]  = '{0, 1, 1, -1, -1, 0, 7, 1, 0, 7};   // stuck-at-0
        tbl[2]  = '{1, 0, 0, -1, -1, 0, 6, 1, 0, 6};   // OR gate, AND expected
        tbl[3]  = '{0, 0, 0, -1, -1, 0, 0, 0, 1, 0};   // rerun clears count
        tbl[4]  = '{2, 0, 0, -1, -1, 0, 3, 3, 0, 3};   // OR vs XOR
        tbl[5]  = '{3, 0, 0, -1, -1, 0, 8, 0, 0, 8};   // OR vs NOR: every pattern
        tbl[6]  = '{0, 0, 3, -1, -1, 0, 0, 0, 1, 0};   // 1-cycle latency, settle 1
        tbl[7]  = '{0, 0, 4, -1, -1, 0, 0, 0, 1, 2};   // 2-cycle latency, settle 1
        tbl[8]  = '{0, 0, 0, 10, -1, 1, 0, 0, 1, 0};   // restart + gate_sel toggle
        tbl[9]  = '{1, 1, 0,  5, -1, 1, 1, 7, 0, 6};   // latched AND, toggled later
        tbl[10] = '{0, 1, 1, -1, 12, 0, -1, 0, 0, -1}; // reset mid-run
        tbl[11] = '{0, 0, 0, -1, -1, 0, 0, 0, 1, 0};   // fresh run after reset

        mode[0] = 0; mode[1] = 0;
        rnd = '0;
        rst = 1'b1; start = 1'b0; gsel = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle();
        rst = 1'b0;
        @(posedge clk);
        cyc++;

        for (int n = 0; n < 12; n++) run(tbl[n]);

        for (int n = 0; n < 6; n++) begin
            vec_t v;
            v = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 20)), -1, 1, -1, 0, 0, -1};
            run(v);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
